// File: rtl/hazard_pkg.sv
// hazard_pkg: forward-select encodings and register index type for the hazard scoreboard
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam int NREG_DEF = 16;
  typedef logic [$clog2(NREG_DEF)-1:0] reg_idx_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: datapath-side controls into and pipeline controls out of the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int NREG = 16,
  parameter int NMC  = 2,
  parameter int CNTW = 16
);
  localparam int AW = $clog2(NREG);
  logic [AW-1:0]   RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic            RegWriteD, MemtoRegE, RegWriteE, PCSrcE;
  logic            RegWriteM, MemtoRegM, MemWriteM, cache_ready, RegWriteW, StatClr;
  logic [NMC-1:0]  MCReqD, MCStartE, MCDone;
  logic            StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [NREG-1:0] PendMask;
  logic [NMC-1:0]  MCBusy;
  logic [CNTW-1:0] StallCount;
  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MCReqD, RA1E, RA2E, WA3E, MemtoRegE, RegWriteE, PCSrcE,
           MCStartE, MCDone, WA3M, RegWriteM, MemtoRegM, MemWriteM, cache_ready, WA3W, RegWriteW, StatClr,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, PendMask, MCBusy, StallCount
  );
  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MCReqD, RA1E, RA2E, WA3E, MemtoRegE, RegWriteE, PCSrcE,
           MCStartE, MCDone, WA3M, RegWriteM, MemtoRegM, MemWriteM, cache_ready, WA3W, RegWriteW, StatClr,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, PendMask, MCBusy, StallCount
  );
endinterface

// File: rtl/hz_mc_tracker.sv
// hz_mc_tracker: destination tag and busy flag of one multi-cycle unit, with set/clear strobes
module hz_mc_tracker #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          done,
  input  logic [AW-1:0] wa,
  output logic          busy,
  output logic          set_stb,
  output logic          clr_stb,
  output logic [AW-1:0] tag
);
  assign set_stb = start;
  assign clr_stb = done & busy;
  // a start after a same-cycle done installs the new tag; a done on an idle unit does nothing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tag  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      tag  <= wa;
      busy <= 1'b1;
    end else if (done) busy <= 1'b0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding, stall/flush and multi-cycle register scoreboard; HAZARD_STALL_CNT_EN builds the stall counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = 16,
  parameter int NMC  = 2,
  parameter int CNTW = 16
) (
  input logic CLK,
  input logic RESETn,
  hazard_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);
  logic [NMC-1:0]  busy, set_stb, clr_stb;
  logic [AW-1:0]   tag [NMC];
  logic [NREG-1:0] pend, pend_nx, set_m, clr_m, keep_m;
  logic            ldr, mem, sb, st, stall_d;
  for (genvar i = 0; i < NMC; i++) begin : g_trk
    hz_mc_tracker #(.AW(AW)) u_trk (
      .clk(CLK), .rst_n(RESETn), .start(bus.MCStartE[i]), .done(bus.MCDone[i]), .wa(bus.WA3E),
      .busy(busy[i]), .set_stb(set_stb[i]), .clr_stb(clr_stb[i]), .tag(tag[i])
    );
  end
  // retire clears first unless another still-busy unit targets the register, then starts set
  always_comb begin
    set_m  = '0;
    clr_m  = '0;
    keep_m = '0;
    for (int i = 0; i < NMC; i++) begin
      if (busy[i] & ~clr_stb[i]) keep_m[tag[i]] = 1'b1;
      if (clr_stb[i]) clr_m[tag[i]] = 1'b1;
      if (set_stb[i]) set_m[bus.WA3E] = 1'b1;
    end
    pend_nx = (pend & ~(clr_m & ~keep_m)) | set_m;
  end
  // scoreboard register
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) pend <= '0;
    else pend <= pend_nx;
  // next-cycle view doubles as the stall view: write-first retire, issuing start already visible
  always_comb begin
    ldr     = (bus.RA1D == bus.WA3E | bus.RA2D == bus.WA3E) & bus.MemtoRegE & bus.RegWriteE;
    mem     = (bus.MemtoRegM | bus.MemWriteM) & ~bus.cache_ready;
    sb      = pend_nx[bus.RA1D] | pend_nx[bus.RA2D] | (pend_nx[bus.WA3D] & bus.RegWriteD);
    st      = |(bus.MCReqD & busy & ~bus.MCDone);
    stall_d = ldr | mem | sb | st;
  end
  assign bus.StallF    = stall_d;
  assign bus.StallD    = stall_d;
  assign bus.StallE    = mem;
  assign bus.StallM    = mem;
  assign bus.FlushE    = (ldr | sb | st) & ~mem;
  assign bus.FlushD    = bus.PCSrcE & ~mem;
  assign bus.ForwardAE = (bus.RA1E == bus.WA3M & bus.RegWriteM) ? FWD_MEM :
                         (bus.RA1E == bus.WA3W & bus.RegWriteW) ? FWD_WB : FWD_RF;
  assign bus.ForwardBE = (bus.RA2E == bus.WA3M & bus.RegWriteM) ? FWD_MEM :
                         (bus.RA2E == bus.WA3W & bus.RegWriteW) ? FWD_WB : FWD_RF;
  assign bus.PendMask  = pend;
  assign bus.MCBusy    = busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNTW-1:0] cnt;
  // saturating stall-cycle counter, clear wins over increment
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) cnt <= '0;
    else if (bus.StatClr) cnt <= '0;
    else if (stall_d & ~&cnt) cnt <= cnt + 1'b1;
  assign bus.StallCount = cnt;
`else
  assign bus.StallCount = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors for forwarding, stalls, scoreboard tracking, counter and async reset
module tb_hazard_scoreboard;
  import hazard_pkg::*;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RESETn;
  int total = 0;
  int bad = 0;
  logic [3:0] exp_cnt = '0;
  hazard_scoreboard_if #(.NREG(16), .NMC(2), .CNTW(4)) bus ();
  hazard_scoreboard #(.NREG(16), .NMC(2), .CNTW(4)) dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK)
    if (RESETn) assert ($countones(bus.MCStartE) <= 1) else $error("two MCStartE pulses share WA3E");
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_st(input string tag, input logic [5:0] exp);
    chk(tag, {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE}, exp);
  endtask
  task automatic chk_sb(input string tag, input logic [15:0] pm, input logic [1:0] bz);
    chk({tag, "_pend"}, bus.PendMask, pm);
    chk({tag, "_busy"}, bus.MCBusy, bz);
  endtask
  task automatic chk_cnt(input string tag);
    chk(tag, bus.StallCount, CNT_EN ? exp_cnt : 4'h0);
  endtask
  task automatic tick(input bit stalled);
    @(posedge CLK);
    if (stalled && exp_cnt != 4'hF) exp_cnt++;
    #1;
  endtask
  task automatic idle();
    {bus.RA1D, bus.RA2D, bus.WA3D, bus.RA1E, bus.RA2E, bus.WA3E, bus.WA3M, bus.WA3W} = '0;
    {bus.RegWriteD, bus.MemtoRegE, bus.RegWriteE, bus.PCSrcE, bus.RegWriteM, bus.MemtoRegM} = '0;
    {bus.MemWriteM, bus.RegWriteW, bus.StatClr} = '0;
    bus.cache_ready = 1'b1;
    {bus.MCReqD, bus.MCStartE, bus.MCDone} = '0;
  endtask
  initial begin
    reg_idx_t r;
    RESETn = 1'b0;
    idle();
    #3;
    chk_sb("rst", 16'h0, 2'b00);
    chk_cnt("rst_cnt");
    chk_st("rst_st", 6'b000000);
    chk("rst_fa", bus.ForwardAE, 2'b00);
    @(negedge CLK) RESETn = 1'b1;
    #1;
    r = 4'd3;
    bus.RA1E = r; bus.WA3M = r; bus.RegWriteM = 1'b1; bus.WA3W = r; bus.RegWriteW = 1'b1;
    #1 chk("fwd_mem", bus.ForwardAE, 2'b10);
    chk("fwd_b_rf", bus.ForwardBE, 2'b00);
    bus.RegWriteM = 1'b0; bus.RA2E = r;
    #1 chk("fwd_wb", bus.ForwardAE, 2'b01);
    chk("fwd_b_wb", bus.ForwardBE, 2'b01);
    bus.RegWriteW = 1'b0;
    #1 chk("fwd_none", bus.ForwardAE, 2'b00);
    idle();
    bus.MemtoRegE = 1'b1; bus.RegWriteE = 1'b1; bus.WA3E = 4'd5; bus.RA2D = 4'd5;
    #1 chk_st("ldu", 6'b110001);
    tick(1);
    idle();
    #1 chk_st("ldu_after", 6'b000000);
    bus.MCStartE = 2'b01; bus.WA3E = 4'd7; bus.RA1D = 4'd7;
    #1 chk_st("raw_issue", 6'b110001);
    tick(1);
    bus.MCStartE = 2'b00; bus.WA3E = 4'd0;
    #1 chk_sb("raw_hold", 16'h0080, 2'b01);
    chk_st("raw_hold_st", 6'b110001);
    tick(1);
    bus.MCDone = 2'b01;
    #1 chk_st("raw_done_st", 6'b000000);
    chk_sb("raw_done", 16'h0080, 2'b01);
    tick(0);
    bus.MCDone = 2'b00;
    #1 chk_sb("raw_clear", 16'h0000, 2'b00);
    idle();
    bus.MCStartE = 2'b01; bus.WA3E = 4'd2;
    #1 chk_st("u0_issue_st", 6'b000000);
    tick(0);
    bus.MCStartE = 2'b10; bus.WA3E = 4'd4;
    tick(0);
    bus.MCStartE = 2'b00; bus.WA3E = 4'd0; bus.MCReqD = 2'b10;
    #1 chk_sb("two_busy", 16'h0014, 2'b11);
    chk_st("struct_st", 6'b110001);
    tick(1);
    bus.MCDone = 2'b10;
    #1 chk_st("struct_done_st", 6'b000000);
    tick(0);
    bus.MCDone = 2'b00; bus.MCReqD = 2'b00;
    #1 chk_sb("u1_retired", 16'h0004, 2'b01);
    bus.MCDone = 2'b01; bus.MCStartE = 2'b01; bus.WA3E = 4'd2; bus.RA1D = 4'd2;
    #1 chk_st("redo_st", 6'b110001);
    tick(1);
    bus.MCDone = 2'b00; bus.MCStartE = 2'b10; bus.RA1D = 4'd0;
    #1 chk_sb("redo_same", 16'h0004, 2'b01);
    tick(0);
    bus.MCStartE = 2'b00; bus.WA3E = 4'd0; bus.MCDone = 2'b01; bus.RA1D = 4'd2;
    #1 chk_sb("shared_tag", 16'h0004, 2'b11);
    chk_st("shared_st", 6'b110001);
    tick(1);
    bus.MCDone = 2'b00; bus.RA1D = 4'd0;
    #1 chk_sb("shared_kept", 16'h0004, 2'b10);
    bus.MCDone = 2'b10;
    tick(0);
    bus.MCDone = 2'b00;
    #1 chk_sb("shared_clear", 16'h0000, 2'b00);
    idle();
    bus.MemtoRegM = 1'b1; bus.cache_ready = 1'b0; bus.PCSrcE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk_st("freeze", 6'b111100);
      tick(1);
    end
    bus.cache_ready = 1'b1;
    #1 chk_st("thaw", 6'b000010);
    tick(0);
    idle();
    #1 chk_cnt("cnt10");
    bus.StatClr = 1'b1; bus.MemtoRegM = 1'b1; bus.cache_ready = 1'b0;
    tick(0);
    exp_cnt = '0;
    #1 chk_cnt("clr_prio");
    bus.StatClr = 1'b0;
    repeat (20) tick(1);
    chk_cnt("saturate");
    idle();
    bus.StatClr = 1'b1;
    tick(0);
    exp_cnt = '0;
    bus.StatClr = 1'b0;
    bus.MCStartE = 2'b01; bus.WA3E = 4'd1;
    tick(0);
    bus.MCStartE = 2'b10; bus.WA3E = 4'd3;
    tick(0);
    idle();
    bus.MemtoRegM = 1'b1; bus.cache_ready = 1'b0;
    repeat (9) tick(1);
    chk_cnt("cnt9");
    chk_sb("pre_rst", 16'h000A, 2'b11);
    #2 RESETn = 1'b0;
    #1 chk_sb("async_rst", 16'h0000, 2'b00);
    chk("async_rst_cnt", bus.StallCount, 4'h0);
    idle();
    @(negedge CLK) RESETn = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit of the 5-stage ARM core.
- Retains the existing functions: M/W operand forwarding, load-use stall, cache-miss freeze and branch flush.
- Adds a register scoreboard that tracks pending writes from NMC independent multi-cycle units (MUL/DIV). This allows several multi-cycle ops to be outstanding at once, replacing the single-unit combinational check.
- Adds a structural-busy stall and a saturating stall-cycle counter.
- Sits beside the datapath and drives the stall/flush/forward controls of every pipeline register.

Parameters:
- NREG, 16, architectural register count.
- AW, $clog2(NREG), register address width.
- NMC, 2, number of multi-cycle units.
- CNTW, 16, stall counter width.

Ports:
- CLK  in  1  core clock.
- RESETn  in  1  asynchronous active-low reset.
- RA1D, RA2D, WA3D  in  AW each  Decode source and destination registers.
- RegWriteD  in  1  Decode instruction writes WA3D.
- MCReqD  in  NMC  one-hot; Decode instruction needs unit i.
- RA1E, RA2E, WA3E  in  AW each  Execute source and destination registers.
- MemtoRegE, RegWriteE, PCSrcE  in  1 each  Execute controls.
- MCStartE  in  NMC  one-cycle pulse; unit i accepted an op writing WA3E.
- MCDone  in  NMC  one-cycle pulse; unit i writes its result to the register file this cycle.
- WA3M  in  AW  Memory-stage destination.
- RegWriteM, MemtoRegM, MemWriteM  in  1 each  Memory-stage controls.
- cache_ready  in  1  cache has completed the current access.
- WA3W  in  AW  Writeback destination.
- RegWriteW  in  1  Writeback write enable.
- StatClr  in  1  synchronous clear of StallCount.
- StallF, StallD, StallE, StallM  out  1 each  pipeline register holds.
- FlushD, FlushE  out  1 each  pipeline register bubbles.
- ForwardAE, ForwardBE  out  2 each  operand source select.
- PendMask  out  NREG  scoreboard bit per register.
- MCBusy  out  NMC  unit i has an outstanding op.
- StallCount  out  CNTW  count of cycles with StallD high.

Behaviour:
- Reset (async, RESETn=0): PendMask=0, MCBusy=0, all unit tags=0, StallCount=0. Combinational outputs follow their equations with an empty scoreboard.
- Forwarding, priority M over W:
  - ForwardAE=10 if RA1E==WA3M & RegWriteM.
  - Else ForwardAE=01 if RA1E==WA3W & RegWriteW.
  - Else ForwardAE=00.
  - ForwardBE is identical, using RA2E.
- Load-use stall: LDRst = (RA1D==WA3E | RA2D==WA3E) & MemtoRegE & RegWriteE.
- Memory-freeze stall: MEMst = (MemtoRegM | MemWriteM) & ~cache_ready.
- Scoreboard data stall: SBst = PendMask[RA1D] | PendMask[RA2D] | (PendMask[WA3D] & RegWriteD), masked as follows:
  - A register whose clearing MCDone fires this cycle does not stall; the register file is write-first.
  - An issuing MCStartE whose WA3E matches RA1D/RA2D/WA3D does stall; the scoreboard bit is set only next cycle.
- Structural stall: STst = OR over i of MCReqD[i] & MCBusy[i] & ~MCDone[i].
- Stall and flush outputs:
  - StallF = StallD = LDRst | MEMst | SBst | STst.
  - StallE = StallM = MEMst.
  - FlushE = (LDRst | SBst | STst) & ~StallE.
  - FlushD = PCSrcE & ~StallE.
- Unit tracker i, updated on the clock edge:
  - On MCStartE[i]: tag[i] <= WA3E, MCBusy[i] <= 1, set PendMask[WA3E].
  - On MCDone[i]: MCBusy[i] <= 0, clear PendMask[tag[i]], unless another unit's tag still targets the same register.
  - Start and Done on the same unit in the same cycle: Done retires the old tag, then Start installs the new one.
  - If the old and new register are equal, the bit stays set.
  - MCStartE is recorded unconditionally; StallE does not suppress it.
  - MCDone on an idle unit is ignored.
  - Two MCStartE pulses with equal WA3E in one cycle are illegal; the bench asserts on this.
- StatClr has priority over increment. StallCount otherwise increments on each cycle StallD=1 and saturates at all-ones.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- Defined: StallCount and StatClr behave as specified above.
- Undefined: the counter register is not built, StallCount is tied to 0, and StatClr is ignored.

Decomposition:
- Package hazard_pkg holds FWD_RF=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10, plus a typedef for the AW-wide register index.
- Sub-module hz_mc_tracker, one instance per unit, generated NMC times. It holds tag/busy and emits a set-strobe and a clear-strobe plus the register index.
- The top level ORs the strobes into PendMask and implements the stall, flush and forward equations and the counter.

Test Plan:
- Forward priority: RA1E=3, WA3M=3 with RegWriteM=1, and WA3W=3 with RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01.
- Load-use: MemtoRegE=RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle, then all 0.
- Multi-cycle RAW: MCStartE[0] with WA3E=7; RA1D=7 held -> stall each cycle, PendMask[7]=1. MCDone[0] pulse -> stall drops that same cycle, PendMask[7]=0 next cycle.
- Two units: unit 0 targets r2, unit 1 targets r4, MCReqD[1] while unit 1 busy -> STst stall. Unit 1 done -> stall drops; PendMask[2] stays 1.
- Cache freeze: MemtoRegM=1, cache_ready=0 for 4 cycles with PCSrcE=1 -> all four stalls=1, FlushD=0, FlushE=0. cache_ready=1 -> FlushD=1.
- Reset mid-op, with HAZARD_STALL_CNT_EN defined: RESETn=0 while both units busy and StallCount=9 -> PendMask, MCBusy and StallCount go to 0 immediately, asynchronously.
